// File: rtl/avr_sram_bridge.sv
// avr_sram_bridge: bridge between the AVR control bus and an external SRAM.
// The address is loaded serially (MSB first) while avr_sreg_en=0. When it is frozen,
// a falling avr_oe/avr_we strobe starts one SRAM read or write cycle. The SRAM strobe
// stays active for WAIT_STATES extra cycles. Data is buffered in both directions, and
// the address can optionally auto-increment.
//
// Ports:
//   avr_clk, avr_reset           clock (rising edge), async active-high reset
//   avr_si, avr_sreg_en          serial address input, shift(0)/freeze(1) select
//   avr_oe, avr_we               AVR read/write strobes, active low
//   avr_data_i/o, avr_data_oe    AVR-side data in/out and drive enable
//   sram_data_i/o, sram_data_oe  SRAM-side data in/out and drive enable
//   sram_addr                    SRAM address (the address register)
//   sram_ce_n/oe_n/we_n          SRAM control strobes, active low
//   busy                         high whenever the FSM is not idle
module avr_sram_bridge #(
    parameter int unsigned ADDR_WIDTH  = 21,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned AUTO_INC    = 1
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset,
    input  logic                  avr_si,
    input  logic                  avr_sreg_en,
    input  logic                  avr_oe,
    input  logic                  avr_we,
    input  logic [DATA_WIDTH-1:0] avr_data_i,
    output logic [DATA_WIDTH-1:0] avr_data_o,
    output logic                  avr_data_oe,
    input  logic [DATA_WIDTH-1:0] sram_data_i,
    output logic [DATA_WIDTH-1:0] sram_data_o,
    output logic                  sram_data_oe,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  busy
);

    localparam int unsigned WAIT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_HOLD = 3'd2,
        S_WR      = 3'd3,
        S_WR_REC  = 3'd4,
        S_WR_HOLD = 3'd5,
        S_INC     = 3'd6
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WAIT_W-1:0]     r_wait;
    logic [DATA_WIDTH-1:0] r_rd_buf;
    logic [DATA_WIDTH-1:0] r_wr_buf;
    logic                  r_oe_prev;
    logic                  r_we_prev;
    logic                  r_ce_n;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic                  r_avr_data_oe;
    logic                  r_sram_data_oe;
    logic                  r_busy;

    logic                  w_oe_fall;
    logic                  w_we_fall;

    // A strobe falls when its registered previous value is 1 and its current value is 0.
    assign w_oe_fall = r_oe_prev & ~avr_oe;
    assign w_we_fall = r_we_prev & ~avr_we;

    // Control FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge avr_clk or posedge avr_reset) begin
        if (avr_reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_wait         <= '0;
            r_rd_buf       <= '0;
            r_wr_buf       <= '0;
            r_oe_prev      <= 1'b1;
            r_we_prev      <= 1'b1;
            r_ce_n         <= 1'b1;
            r_oe_n         <= 1'b1;
            r_we_n         <= 1'b1;
            r_avr_data_oe  <= 1'b0;
            r_sram_data_oe <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_oe_prev <= avr_oe;
            r_we_prev <= avr_we;
            case (r_state)
                S_IDLE: begin
                    if (!avr_sreg_en) begin
                        r_addr <= {r_addr[ADDR_WIDTH-2:0], avr_si};
                    end else if (w_we_fall) begin
                        // When both strobes fall together, the write wins and the read is dropped.
                        r_wr_buf       <= avr_data_i;
                        r_wait         <= WAIT_W'(WAIT_STATES);
                        r_state        <= S_WR;
                        r_ce_n         <= 1'b0;
                        r_we_n         <= 1'b0;
                        r_sram_data_oe <= 1'b1;
                        r_busy         <= 1'b1;
                    end else if (w_oe_fall) begin
                        r_wait  <= WAIT_W'(WAIT_STATES);
                        r_state <= S_RD;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RD: begin
                    if (r_wait == '0) begin
                        r_rd_buf      <= sram_data_i;
                        r_state       <= S_RD_HOLD;
                        r_oe_n        <= 1'b1;
                        r_avr_data_oe <= 1'b1;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_RD_HOLD: begin
                    if (avr_oe) begin
                        r_state       <= S_INC;
                        r_ce_n        <= 1'b1;
                        r_avr_data_oe <= 1'b0;
                    end
                end
                S_WR: begin
                    if (r_wait == '0) begin
                        r_state <= S_WR_REC;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_WR_REC: begin
                    // Data stays driven for one cycle after we_n rises (SRAM hold time).
                    r_state        <= S_WR_HOLD;
                    r_ce_n         <= 1'b1;
                    r_sram_data_oe <= 1'b0;
                end
                S_WR_HOLD: begin
                    if (avr_we) begin
                        r_state <= S_INC;
                    end
                end
                S_INC: begin
                    if (AUTO_INC != 0) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_ce_n         <= 1'b1;
                    r_oe_n         <= 1'b1;
                    r_we_n         <= 1'b1;
                    r_avr_data_oe  <= 1'b0;
                    r_sram_data_oe <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign sram_addr    = r_addr;
    assign avr_data_o   = r_rd_buf;
    assign sram_data_o  = r_wr_buf;
    assign avr_data_oe  = r_avr_data_oe;
    assign sram_data_oe = r_sram_data_oe;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;
    assign busy         = r_busy;

endmodule

// File: doc/avr_sram_bridge.md
Name: avr_sram_bridge

Overview:
Parametrised bridge between the AVR control bus and the external SRAM. It replaces the fixed sreg + bus_fsm pair. An internal shift register takes the serially loaded address. A strobe-driven state machine then performs SRAM read and write cycles with configurable wait states, buffered data in both directions and optional address auto-increment. It sits between the AVR pins and the SRAM pins at the top of the CPLD design.

Parameters:
ADDR_WIDTH, 21, SRAM address width and shift-register length
DATA_WIDTH, 8, data bus width on both sides
WAIT_STATES, 1, extra cycles the SRAM strobe is held active (0..7)
AUTO_INC, 1, 1 = address increments after each completed access; 0 = address static

Ports:
avr_clk  in  1  system clock; all logic on rising edge
avr_reset  in  1  asynchronous, active-high reset
avr_si  in  1  serial address input, MSB first
avr_sreg_en  in  1  0 = shift address in; 1 = address frozen and valid for accesses
avr_oe  in  1  AVR read strobe, active low
avr_we  in  1  AVR write strobe, active low
avr_data_i  in  DATA_WIDTH  data from AVR
avr_data_o  out  DATA_WIDTH  read data to AVR
avr_data_oe  out  1  drive enable for avr_data_o
sram_data_i  in  DATA_WIDTH  data from SRAM
sram_data_o  out  DATA_WIDTH  write data to SRAM
sram_data_oe  out  1  drive enable for sram_data_o
sram_addr  out  ADDR_WIDTH  SRAM address, always equal to the address register
sram_ce_n  out  1  SRAM chip enable, active low
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, avr_reset=1):
  - addr=0, state=IDLE.
  - sram_ce_n, sram_oe_n and sram_we_n = 1.
  - avr_data_oe and sram_data_oe = 0.
  - Read and write buffers = 0; busy = 0.
  - Strobe history registers = 1.
  - Reset mid-access aborts immediately; no partial write completes after release.
- Address shifting:
  - In IDLE with avr_sreg_en=0, each clock does addr <= {addr[ADDR_WIDTH-2:0], avr_si}.
  - Outside IDLE, shifting is suppressed.
- Strobe detection:
  - A falling edge is the registered previous value = 1 while the current value = 0.
  - Strobes are synchronous to avr_clk.
  - Strobes are acted on only in IDLE with avr_sreg_en=1; otherwise they are ignored.
  - If both fall in the same cycle, the write wins and the read is discarded.
- FSM states: IDLE, RD, RD_HOLD, WR, WR_REC, WR_HOLD, INC.
- IDLE:
  - avr_oe falling -> RD, wait counter = WAIT_STATES.
  - avr_we falling -> wr_buf <= avr_data_i (same edge), then WR, wait counter = WAIT_STATES.
- RD:
  - sram_ce_n=0, sram_oe_n=0.
  - Counter decrements each cycle.
  - On the cycle where the counter is 0: rd_buf <= sram_data_i, go to RD_HOLD.
  - Total RD duration = WAIT_STATES+1 cycles.
- RD_HOLD:
  - sram_ce_n=0, sram_oe_n=1.
  - avr_data_o=rd_buf, avr_data_oe=1.
  - Stays while avr_oe=0; avr_oe=1 -> INC.
- WR:
  - sram_ce_n=0, sram_we_n=0, sram_data_oe=1, sram_data_o=wr_buf for WAIT_STATES+1 cycles, then WR_REC.
- WR_REC:
  - One cycle: sram_we_n=1, data still driven (hold time), ce_n=0.
  - Then WR_HOLD.
- WR_HOLD:
  - All SRAM strobes = 1, sram_data_oe=0.
  - Waits for avr_we=1, then INC.
- INC:
  - If AUTO_INC=1: addr <= addr+1, modulo 2^ADDR_WIDTH (all-ones wraps to 0).
  - Next state IDLE, one cycle.
  - Outputs as in IDLE.
- Timing and bus rules:
  - Minimum latency from a sampled avr_oe fall to avr_data_oe=1 is WAIT_STATES+2 cycles.
  - avr_data_oe and sram_data_oe are never high together.

Test Plan:
- Shift-in: sreg_en=0, shift 21 bits of 0x0A5A5F MSB first, then sreg_en=1 -> sram_addr=0x0A5A5F.
- Read path:
  - Setup: WAIT_STATES=1, sram_data_i=0xAA, avr_oe pulled low.
  - Required: sram_oe_n low for 2 cycles; avr_data_o=0xAA with avr_data_oe=1 at the 3rd cycle.
  - On avr_oe release with AUTO_INC=1: sram_addr=0x0A5A60.
- Read buffer hold: change sram_data_i to 0xBB during RD_HOLD -> avr_data_o stays 0xAA; a second oe pulse returns 0xBB at the incremented address.
- Write path:
  - Setup: avr_data_i=0xEE, avr_we pulled low.
  - Required: sram_data_o=0xEE with sram_data_oe=1, sram_we_n low for 2 cycles, then 1 recovery cycle with data driven.
  - Required: avr_data_oe stays 0 throughout.
- Wrap and priority:
  - Wrap: shift in 0x1FFFFF, complete one read -> sram_addr=0x000000.
  - Priority: assert oe and we low in the same cycle -> a write cycle occurs and sram_oe_n stays high.
- Reset mid-write: assert avr_reset during WR -> sram_we_n=1, sram_ce_n=1, sram_data_oe=0, sram_addr=0 immediately (asynchronously); busy=0.
